// File: rtl/rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rs_issue_scheduler
// Brief    : Reservation station with CDB wakeup, age-matrix oldest-ready
//            select and valid/ready issue to a single functional unit.
// Revision : 1.0 - initial release
// ============================================================================
module rs_issue_scheduler #(
    parameter int RS_SIZE  = 4,
    parameter int REG_SIZE = 64,
    parameter int TAG_W    = 5
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_flush,
    input  logic                           i_alloc_valid,
    output logic                           o_alloc_ready,
    input  logic                           i_alloc_op1_valid,
    input  logic [TAG_W-1:0]               i_alloc_op1_tag,
    input  logic [REG_SIZE-1:0]            i_alloc_op1_value,
    input  logic                           i_alloc_op2_valid,
    input  logic [TAG_W-1:0]               i_alloc_op2_tag,
    input  logic [REG_SIZE-1:0]            i_alloc_op2_value,
    input  logic [TAG_W-1:0]               i_alloc_dst_tag,
    input  logic                           i_cdb_valid,
    input  logic [TAG_W-1:0]               i_cdb_tag,
    input  logic [REG_SIZE-1:0]            i_cdb_value,
    output logic                           o_issue_valid,
    input  logic                           i_issue_ready,
    output logic [REG_SIZE-1:0]            o_issue_op1,
    output logic [REG_SIZE-1:0]            o_issue_op2,
    output logic [TAG_W-1:0]               o_issue_dst_tag,
    output logic [$clog2(RS_SIZE+1)-1:0]   o_count
);

    localparam int                 c_IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int                 c_CNT_W = $clog2(RS_SIZE + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(RS_SIZE);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    // Control state (reset)
    logic [RS_SIZE-1:0]  r_busy;
    logic [RS_SIZE-1:0]  r_older [RS_SIZE];
    logic                r_locked;
    logic [c_IDX_W-1:0]  r_lock_idx;
    logic [c_CNT_W-1:0]  r_count;

    // Payload state (qualified by r_busy, no reset needed)
    logic [RS_SIZE-1:0]  r_op1_valid;
    logic [RS_SIZE-1:0]  r_op2_valid;
    logic [TAG_W-1:0]    r_op1_tag   [RS_SIZE];
    logic [TAG_W-1:0]    r_op2_tag   [RS_SIZE];
    logic [REG_SIZE-1:0] r_op1_value [RS_SIZE];
    logic [REG_SIZE-1:0] r_op2_value [RS_SIZE];
    logic [TAG_W-1:0]    r_dst_tag   [RS_SIZE];

    logic [RS_SIZE-1:0]  w_ready;
    logic [RS_SIZE-1:0]  w_is_oldest;
    logic [c_IDX_W-1:0]  w_oldest_idx;
    logic [c_IDX_W-1:0]  w_free_idx;
    logic [c_IDX_W-1:0]  w_sel;
    logic                w_alloc_ready;
    logic                w_issue_valid;
    logic                w_alloc_fire;
    logic                w_issue_fire;
    logic                w_op1_bypass;
    logic                w_op2_bypass;

    assign w_ready       = r_busy & r_op1_valid & r_op2_valid;
    assign w_alloc_ready = (r_count < c_FULL);
    assign w_issue_valid = !i_flush && (r_locked || (|w_ready));
    assign w_alloc_fire  = i_alloc_valid && w_alloc_ready && !i_flush;
    assign w_issue_fire  = w_issue_valid && i_issue_ready;
    assign w_sel         = r_locked ? r_lock_idx : w_oldest_idx;

    assign w_op1_bypass  = !i_alloc_op1_valid && i_cdb_valid && (i_alloc_op1_tag == i_cdb_tag);
    assign w_op2_bypass  = !i_alloc_op2_valid && i_cdb_valid && (i_alloc_op2_tag == i_cdb_tag);

    // An entry is oldest-ready when it is older than every other ready entry
    always_comb begin
        w_is_oldest = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_is_oldest[i] = w_ready[i];
            for (int j = 0; j < RS_SIZE; j++) begin
                if (j != i && w_ready[j] && !r_older[i][j]) begin
                    w_is_oldest[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_oldest_idx = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (w_is_oldest[i]) begin
                w_oldest_idx = c_IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_idx = c_IDX_W'(i);
            end
        end
    end

    assign o_alloc_ready   = w_alloc_ready;
    assign o_count         = r_count;
    assign o_issue_valid   = w_issue_valid;
    assign o_issue_op1     = w_issue_valid ? r_op1_value[w_sel] : '0;
    assign o_issue_op2     = w_issue_valid ? r_op2_value[w_sel] : '0;
    assign o_issue_dst_tag = w_issue_valid ? r_dst_tag[w_sel]   : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_busy     <= '0;
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
            r_count    <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_older[i] <= '0;
            end
        end else begin
            if (w_issue_valid && !i_issue_ready) begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_sel;
            end
            if (w_issue_fire) begin
                r_locked      <= 1'b0;
                r_busy[w_sel] <= 1'b0;
                r_older[w_sel] <= '0;
                for (int j = 0; j < RS_SIZE; j++) begin
                    r_older[j][w_sel] <= 1'b0;
                end
            end
            // The free slot is never the issuing one, so these writes never collide
            if (w_alloc_fire) begin
                r_busy[w_free_idx]  <= 1'b1;
                r_older[w_free_idx] <= '0;
                for (int j = 0; j < RS_SIZE; j++) begin
                    if (r_busy[j] && !(w_issue_fire && (w_sel == c_IDX_W'(j)))) begin
                        r_older[j][w_free_idx] <= 1'b1;
                    end
                end
            end
            if (w_alloc_fire && !w_issue_fire) begin
                r_count <= r_count + c_ONE;
            end else if (!w_alloc_fire && w_issue_fire) begin
                r_count <= r_count - c_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (i_cdb_valid && r_busy[i]) begin
                if (!r_op1_valid[i] && (r_op1_tag[i] == i_cdb_tag)) begin
                    r_op1_valid[i] <= 1'b1;
                    r_op1_value[i] <= i_cdb_value;
                end
                if (!r_op2_valid[i] && (r_op2_tag[i] == i_cdb_tag)) begin
                    r_op2_valid[i] <= 1'b1;
                    r_op2_value[i] <= i_cdb_value;
                end
            end
        end
        if (w_alloc_fire) begin
            r_op1_valid[w_free_idx] <= i_alloc_op1_valid || w_op1_bypass;
            r_op1_tag[w_free_idx]   <= i_alloc_op1_tag;
            r_op1_value[w_free_idx] <= w_op1_bypass ? i_cdb_value : i_alloc_op1_value;
            r_op2_valid[w_free_idx] <= i_alloc_op2_valid || w_op2_bypass;
            r_op2_tag[w_free_idx]   <= i_alloc_op2_tag;
            r_op2_value[w_free_idx] <= w_op2_bypass ? i_cdb_value : i_alloc_op2_value;
            r_dst_tag[w_free_idx]   <= i_alloc_dst_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_issue_scheduler
// Brief    : Scenario bench for rs_issue_scheduler with an issue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_issue_scheduler;

    localparam int RS_SIZE  = 4;
    localparam int REG_SIZE = 64;
    localparam int TAG_W    = 5;

    typedef struct packed {
        logic [REG_SIZE-1:0] op1;
        logic [REG_SIZE-1:0] op2;
        logic [TAG_W-1:0]    dst;
    } exp_t;

    logic                i_clk = 1'b0;
    logic                i_reset;
    logic                i_flush;
    logic                i_alloc_valid;
    logic                o_alloc_ready;
    logic                i_alloc_op1_valid;
    logic [TAG_W-1:0]    i_alloc_op1_tag;
    logic [REG_SIZE-1:0] i_alloc_op1_value;
    logic                i_alloc_op2_valid;
    logic [TAG_W-1:0]    i_alloc_op2_tag;
    logic [REG_SIZE-1:0] i_alloc_op2_value;
    logic [TAG_W-1:0]    i_alloc_dst_tag;
    logic                i_cdb_valid;
    logic [TAG_W-1:0]    i_cdb_tag;
    logic [REG_SIZE-1:0] i_cdb_value;
    logic                o_issue_valid;
    logic                i_issue_ready;
    logic [REG_SIZE-1:0] o_issue_op1;
    logic [REG_SIZE-1:0] o_issue_op2;
    logic [TAG_W-1:0]    o_issue_dst_tag;
    logic [2:0]          o_count;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t m_exp;

    rs_issue_scheduler #(.RS_SIZE(RS_SIZE), .REG_SIZE(REG_SIZE), .TAG_W(TAG_W)) u_dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_flush           (i_flush),
        .i_alloc_valid     (i_alloc_valid),
        .o_alloc_ready     (o_alloc_ready),
        .i_alloc_op1_valid (i_alloc_op1_valid),
        .i_alloc_op1_tag   (i_alloc_op1_tag),
        .i_alloc_op1_value (i_alloc_op1_value),
        .i_alloc_op2_valid (i_alloc_op2_valid),
        .i_alloc_op2_tag   (i_alloc_op2_tag),
        .i_alloc_op2_value (i_alloc_op2_value),
        .i_alloc_dst_tag   (i_alloc_dst_tag),
        .i_cdb_valid       (i_cdb_valid),
        .i_cdb_tag         (i_cdb_tag),
        .i_cdb_value       (i_cdb_value),
        .o_issue_valid     (o_issue_valid),
        .i_issue_ready     (i_issue_ready),
        .o_issue_op1       (o_issue_op1),
        .o_issue_op2       (o_issue_op2),
        .o_issue_dst_tag   (o_issue_dst_tag),
        .o_count           (o_count)
    );

    always #5 i_clk = ~i_clk;

    // Every accepted issue must match the next scoreboard entry, in order
    always @(negedge i_clk) begin
        if (i_reset === 1'b0 && o_issue_valid === 1'b1 && i_issue_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got dst=%0h op1=%0h op2=%0h, required no issue",
                         o_issue_dst_tag, o_issue_op1, o_issue_op2);
            end else begin
                m_exp = sb.pop_front();
                if (o_issue_op1 !== m_exp.op1 || o_issue_op2 !== m_exp.op2 || o_issue_dst_tag !== m_exp.dst) begin
                    errors++;
                    $display("FAIL issue_scoreboard: got dst=%0h op1=%0h op2=%0h, required dst=%0h op1=%0h op2=%0h",
                             o_issue_dst_tag, o_issue_op1, o_issue_op2, m_exp.dst, m_exp.op1, m_exp.op2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_alloc(input logic v1, input logic [TAG_W-1:0] t1, input logic [REG_SIZE-1:0] x1,
                               input logic v2, input logic [TAG_W-1:0] t2, input logic [REG_SIZE-1:0] x2,
                               input logic [TAG_W-1:0] dst);
        i_alloc_valid     = 1'b1;
        i_alloc_op1_valid = v1;
        i_alloc_op1_tag   = t1;
        i_alloc_op1_value = x1;
        i_alloc_op2_valid = v2;
        i_alloc_op2_tag   = t2;
        i_alloc_op2_value = x2;
        i_alloc_dst_tag   = dst;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_count !== 3'd0 || o_alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_occupancy: got count=%0d ready=%0b, required count=0 ready=1", o_count, o_alloc_ready);
        end
        checks++;
        if (o_issue_valid !== 1'b0 || o_issue_op1 !== '0 || o_issue_op2 !== '0 || o_issue_dst_tag !== '0) begin
            errors++;
            $display("FAIL reset_issue: got valid=%0b op1=%0h op2=%0h dst=%0h, required all 0",
                     o_issue_valid, o_issue_op1, o_issue_op2, o_issue_dst_tag);
        end
        tick();
    endtask

    task automatic test_single();
        i_issue_ready = 1'b1;
        drive_alloc(1'b1, 5'd0, 64'd5, 1'b1, 5'd0, 64'd7, 5'd3);
        sb.push_back('{64'd5, 64'd7, 5'd3});
        @(negedge i_clk);
        checks++;
        if (o_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got valid=%0b in alloc cycle, required 0", o_issue_valid);
        end
        tick();
        i_alloc_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_issue_valid !== 1'b1 || o_issue_op1 !== 64'd5 || o_issue_op2 !== 64'd7 || o_issue_dst_tag !== 5'd3) begin
            errors++;
            $display("FAIL single_issue: got valid=%0b op1=%0h op2=%0h dst=%0h, required 1/5/7/3",
                     o_issue_valid, o_issue_op1, o_issue_op2, o_issue_dst_tag);
        end
        tick();
        @(negedge i_clk);
        checks++;
        if (o_count !== 3'd0 || o_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got count=%0d valid=%0b, required 0/0", o_count, o_issue_valid);
        end
        tick();
    endtask

    task automatic test_wakeup();
        i_issue_ready = 1'b1;
        drive_alloc(1'b0, 5'd9, 64'd0, 1'b1, 5'd0, 64'd1, 5'd10);
        tick();
        drive_alloc(1'b1, 5'd0, 64'd2, 1'b1, 5'd0, 64'd3, 5'd11);
        sb.push_back('{64'd2, 64'd3, 5'd11});
        sb.push_back('{64'h2A, 64'd1, 5'd10});
        tick();
        i_alloc_valid = 1'b0;
        i_cdb_valid   = 1'b1;
        i_cdb_tag     = 5'd9;
        i_cdb_value   = 64'h2A;
        @(negedge i_clk);
        checks++;
        if (o_issue_valid !== 1'b1 || o_issue_dst_tag !== 5'd11) begin
            errors++;
            $display("FAIL wakeup_ready_first: got valid=%0b dst=%0h, required 1/b", o_issue_valid, o_issue_dst_tag);
        end
        tick();
        i_cdb_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_issue_valid !== 1'b1 || o_issue_op1 !== 64'h2A || o_issue_op2 !== 64'd1 || o_issue_dst_tag !== 5'd10) begin
            errors++;
            $display("FAIL wakeup_capture: got valid=%0b op1=%0h op2=%0h dst=%0h, required 1/2a/1/a",
                     o_issue_valid, o_issue_op1, o_issue_op2, o_issue_dst_tag);
        end
        tick();
        @(negedge i_clk);
        checks++;
        if (o_count !== 3'd0) begin
            errors++;
            $display("FAIL wakeup_drain: got count=%0d, required 0", o_count);
        end
        tick();
    endtask

    task automatic test_lock();
        i_issue_ready = 1'b0;
        drive_alloc(1'b0, 5'd4, 64'd0, 1'b1, 5'd0, 64'h10, 5'd1);
        tick();
        drive_alloc(1'b1, 5'd0, 64'hB1, 1'b1, 5'd0, 64'hB2, 5'd2);
        tick();
        drive_alloc(1'b1, 5'd0, 64'hC1, 1'b1, 5'd0, 64'hC2, 5'd3);
        sb.push_back('{64'hB1, 64'hB2, 5'd2});
        sb.push_back('{64'h44, 64'h10, 5'd1});
        sb.push_back('{64'hC1, 64'hC2, 5'd3});
        tick();
        i_alloc_valid = 1'b0;
        i_cdb_valid   = 1'b1;
        i_cdb_tag     = 5'd4;
        i_cdb_value   = 64'h44;
        @(negedge i_clk);
        checks++;
        if (o_issue_valid !== 1'b1 || o_issue_dst_tag !== 5'd2 || o_issue_op1 !== 64'hB1) begin
            errors++;
            $display("FAIL lock_select: got valid=%0b dst=%0h op1=%0h, required 1/2/b1", o_issue_valid, o_issue_dst_tag, o_issue_op1);
        end
        tick();
        i_cdb_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_issue_valid !== 1'b1 || o_issue_dst_tag !== 5'd2 || o_issue_op2 !== 64'hB2) begin
            errors++;
            $display("FAIL lock_hold: got valid=%0b dst=%0h op2=%0h, required 1/2/b2", o_issue_valid, o_issue_dst_tag, o_issue_op2);
        end
        tick();
        i_issue_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_issue_valid !== 1'b1) begin
                errors++;
                $display("FAIL lock_consecutive: got valid=%0b at step %0d, required 1", o_issue_valid, k);
            end
            tick();
        end
        @(negedge i_clk);
        checks++;
        if (o_issue_valid !== 1'b0 || o_count !== 3'd0) begin
            errors++;
            $display("FAIL lock_drain: got valid=%0b count=%0d, required 0/0", o_issue_valid, o_count);
        end
        tick();
    endtask

    task automatic test_full();
        i_issue_ready = 1'b0;
        for (int k = 0; k < RS_SIZE; k++) begin
            drive_alloc(1'b0, TAG_W'(20 + k), 64'd0, 1'b1, 5'd0, 64'h100 + 64'(k), TAG_W'(4 + k));
            tick();
        end
        drive_alloc(1'b1, 5'd0, 64'hEE, 1'b1, 5'd0, 64'hEF, 5'd9);
        @(negedge i_clk);
        checks++;
        if (o_alloc_ready !== 1'b0 || o_count !== 3'd4 || o_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_state: got ready=%0b count=%0d valid=%0b, required 0/4/0", o_alloc_ready, o_count, o_issue_valid);
        end
        tick();
        i_alloc_valid = 1'b0;
        i_cdb_valid   = 1'b1;
        i_cdb_tag     = 5'd21;
        i_cdb_value   = 64'h55;
        sb.push_back('{64'h55, 64'h101, 5'd5});
        @(negedge i_clk);
        checks++;
        if (o_count !== 3'd4) begin
            errors++;
            $display("FAIL full_ignored_alloc: got count=%0d, required 4", o_count);
        end
        tick();
        i_cdb_valid   = 1'b0;
        i_issue_ready = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_issue_valid !== 1'b1 || o_issue_dst_tag !== 5'd5 || o_alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_issue_cycle: got valid=%0b dst=%0h ready=%0b, required 1/5/0",
                     o_issue_valid, o_issue_dst_tag, o_alloc_ready);
        end
        tick();
        @(negedge i_clk);
        checks++;
        if (o_alloc_ready !== 1'b1 || o_count !== 3'd3 || o_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_after_issue: got ready=%0b count=%0d valid=%0b, required 1/3/0",
                     o_alloc_ready, o_count, o_issue_valid);
        end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_count !== 3'd0) begin
            errors++;
            $display("FAIL full_flush: got count=%0d, required 0", o_count);
        end
        tick();
    endtask

    task automatic test_bypass_flush();
        i_issue_ready = 1'b1;
        drive_alloc(1'b1, 5'd0, 64'h22, 1'b0, 5'd6, 64'd0, 5'd8);
        i_cdb_valid = 1'b1;
        i_cdb_tag   = 5'd6;
        i_cdb_value = 64'h11;
        sb.push_back('{64'h22, 64'h11, 5'd8});
        tick();
        i_alloc_valid = 1'b0;
        i_cdb_valid   = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_issue_valid !== 1'b1 || o_issue_op2 !== 64'h11 || o_issue_dst_tag !== 5'd8) begin
            errors++;
            $display("FAIL bypass_alloc: got valid=%0b op2=%0h dst=%0h, required 1/11/8", o_issue_valid, o_issue_op2, o_issue_dst_tag);
        end
        tick();
        i_issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_alloc(1'b1, 5'd0, 64'h60 + 64'(k), 1'b1, 5'd0, 64'h70, TAG_W'(12 + k));
            tick();
        end
        drive_alloc(1'b1, 5'd0, 64'h99, 1'b1, 5'd0, 64'h98, 5'd15);
        i_flush = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_issue_valid !== 1'b0 || o_count !== 3'd3) begin
            errors++;
            $display("FAIL flush_forces_invalid: got valid=%0b count=%0d, required 0/3", o_issue_valid, o_count);
        end
        tick();
        i_flush       = 1'b0;
        i_alloc_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_count !== 3'd0 || o_issue_valid !== 1'b0 || o_alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: got count=%0d valid=%0b ready=%0b, required 0/0/1", o_count, o_issue_valid, o_alloc_ready);
        end
        tick();
        i_issue_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        i_issue_ready = 1'b1;
        drive_alloc(1'b1, 5'd0, 64'h300, 1'b1, 5'd0, 64'h400, 5'd0);
        sb.push_back('{64'h300, 64'h400, 5'd0});
        tick();
        for (int k = 1; k < 6; k++) begin
            drive_alloc(1'b1, 5'd0, 64'h300 + 64'(k), 1'b1, 5'd0, 64'h400 + 64'(k), TAG_W'(k));
            sb.push_back('{64'h300 + 64'(k), 64'h400 + 64'(k), TAG_W'(k)});
            @(negedge i_clk);
            checks++;
            if (o_issue_valid !== 1'b1 || o_issue_dst_tag !== TAG_W'(k - 1) || o_count !== 3'd1) begin
                errors++;
                $display("FAIL b2b_stream: got valid=%0b dst=%0h count=%0d, required 1/%0h/1",
                         o_issue_valid, o_issue_dst_tag, o_count, k - 1);
            end
            tick();
        end
        i_alloc_valid = 1'b0;
        tick();
        @(negedge i_clk);
        checks++;
        if (o_count !== 3'd0 || o_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got count=%0d valid=%0b, required 0/0", o_count, o_issue_valid);
        end
        tick();
    endtask

    initial begin
        i_reset           = 1'b1;
        i_flush           = 1'b0;
        i_alloc_valid     = 1'b0;
        i_alloc_op1_valid = 1'b0;
        i_alloc_op1_tag   = '0;
        i_alloc_op1_value = '0;
        i_alloc_op2_valid = 1'b0;
        i_alloc_op2_tag   = '0;
        i_alloc_op2_value = '0;
        i_alloc_dst_tag   = '0;
        i_cdb_valid       = 1'b0;
        i_cdb_tag         = '0;
        i_cdb_value       = '0;
        i_issue_ready     = 1'b0;

        test_reset();
        test_single();
        test_wakeup();
        test_lock();
        test_full();
        test_bypass_flush();
        test_back_to_back();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending issues, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
- Reservation-station controller for the out-of-order core: holds up to RS_SIZE two-operand entries and captures common-data-bus (CDB) wakeups into waiting operands.
- Each cycle it selects the oldest entry whose operands are both valid and issues it to one functional unit over a valid/ready handshake.
- Sits between rename/dispatch (allocation side) and the execution unit (issue side); exports occupancy for debug.

Parameters:
RS_SIZE, 4, number of entries (>=2)
REG_SIZE, 64, operand value width
TAG_W, 5, operand/destination tag width (matches GPR index width)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_flush  in  1  synchronous clear of all entries (pipeline squash)
i_alloc_valid  in  1  dispatch presents an entry
o_alloc_ready  out  1  at least one free slot
i_alloc_op1_valid  in  1  op1 value already available
i_alloc_op1_tag  in  TAG_W  producer tag if op1 not valid
i_alloc_op1_value  in  REG_SIZE  op1 value if valid
i_alloc_op2_valid / i_alloc_op2_tag / i_alloc_op2_value  in  1/TAG_W/REG_SIZE  same for op2
i_alloc_dst_tag  in  TAG_W  destination tag carried to issue
i_cdb_valid  in  1  result broadcast valid
i_cdb_tag  in  TAG_W  broadcast tag
i_cdb_value  in  REG_SIZE  broadcast value
o_issue_valid  out  1  selected entry available
i_issue_ready  in  1  functional unit accepts
o_issue_op1  out  REG_SIZE  selected op1 value
o_issue_op2  out  REG_SIZE  selected op2 value
o_issue_dst_tag  out  TAG_W  selected destination tag
o_count  out  $clog2(RS_SIZE+1)  occupied entries

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is synchronous and active-high.
- State per entry: busy; op1/op2 {valid, tag, value}; dst_tag. Also an RS_SIZE x RS_SIZE age matrix older[i][j], plus issue lock {locked, idx}.
- Reset (and i_flush, same edge effect): all busy=0, locked=0, age matrix cleared.
  - Outputs after reset: o_count=0, o_alloc_ready=1, o_issue_valid=0, o_issue_op1/op2/dst_tag=0.
  - i_flush has priority over alloc, CDB and issue in the same cycle.
  - o_issue_valid is forced 0 while i_flush=1.
- Allocation:
  - o_alloc_ready = (o_count < RS_SIZE), decoded from registered state only.
  - A slot freed by an issue in the same cycle is NOT reusable that cycle.
  - Fire = i_alloc_valid && o_alloc_ready. The entry is written at the edge into the lowest-index free slot k.
  - Age update on fire: older[j][k]=1 for every busy j; older[k][*]=0.
  - Alloc-time bypass: if an incoming operand has valid=0, i_cdb_valid=1 and tag==i_cdb_tag, it is stored valid with i_cdb_value.
  - i_alloc_valid while not ready is ignored (no state change).
- Wakeup:
  - On i_cdb_valid, every busy entry operand with valid=0 and tag==i_cdb_tag captures i_cdb_value and sets valid at the edge.
  - Both operands of one entry may wake in the same cycle.
  - No same-cycle bypass to issue: a woken entry is eligible from the next cycle.
- Selection:
  - ready_i = busy_i && op1.valid && op2.valid.
  - If locked: selected = idx.
  - Else: selected = the ready i such that older[i][j]=1 for every other ready j (unique oldest).
  - o_issue_valid = locked || any ready_i.
  - o_issue_* show the selected entry combinationally from registered state; they are 0 when o_issue_valid=0.
- Handshake:
  - o_issue_valid && !i_issue_ready: set locked=1, idx=selected. Outputs stay stable until accepted, even if an older entry becomes ready.
  - o_issue_valid && i_issue_ready: clear busy[selected], clear its age row and column, locked=0. The next selection occurs the following cycle.
  - o_issue_valid must not drop once asserted except via i_flush/i_reset.
- Occupancy: o_count is a registered count. It increments on alloc fire, decrements on issue fire, and is net unchanged when both occur. It never exceeds RS_SIZE.
- Latency: entry allocated ready at edge t is visible on o_issue_valid in cycle t+1 at the earliest. Throughput is one issue per cycle.

Test Plan:
- Assert i_reset 2 cycles -> o_count=0, o_alloc_ready=1, o_issue_valid=0, issue data 0.
- Alloc {op1 valid 5, op2 valid 7, dst 3}, i_issue_ready=1 -> next cycle o_issue_valid=1, op1=5, op2=7, dst=3; the cycle after, o_count=0 and o_issue_valid=0.
- Alloc A {op1 waiting tag 9, op2 valid 1}, then B ready {2,3} -> B issues first. CDB tag 9 value 0x2A -> A issues the next cycle with op1=0x2A, op2=1.
- Alloc A (waiting tag 4), B ready, C ready; i_issue_ready=0 -> B locked. Broadcast tag 4 -> outputs stay B. Raise ready -> B, then A (oldest), then C on consecutive cycles.
- Fill 4 entries (none ready) -> o_alloc_ready=0, a further i_alloc_valid is ignored, o_count=4. Wake and issue one -> o_alloc_ready=1 the cycle after issue, not during it.
- Alloc with op2 waiting tag 6 while i_cdb_valid tag 6 value 0x11 in the same cycle -> entry issues next cycle with op2=0x11. Then i_flush with 3 busy entries and pending alloc -> o_count=0, o_issue_valid=0 next cycle, and the alloc is dropped.
